// File: rtl/poly_uniform_gamma1_stream.sv
// poly_uniform_gamma1_stream
//   Streaming gamma1 mask sampler. Takes SHAKE256 squeeze blocks over a
//   valid/ready handshake, bit-unpacks (GAMMA1_BITS+1)-bit fields LSB-first
//   and emits N coefficients z = GAMMA1 - t, one per handshake.
//
// Ports
//   i_clock, i_reset     rising-edge clock, synchronous active-high reset
//   i_start              begin one polynomial (sampled only in IDLE)
//   o_busy               high while a polynomial is in progress
//   o_done               one-cycle pulse after the last coefficient handshake
//   o_blk_ready          block requested
//   i_blk_valid          i_blk_data valid
//   i_blk_data           squeeze block, byte 0 in bits [7:0]
//   o_coef_valid         o_coef_data valid
//   i_coef_ready         downstream accepts
//   o_coef_data          sign-extended GAMMA1 - t
//   o_coef_idx           index of the coefficient on o_coef_data
//                        (only when POLY_GAMMA1_STREAM_IDX_EN is defined)
//
// Optional feature macro: POLY_GAMMA1_STREAM_IDX_EN
module poly_uniform_gamma1_stream #(
    parameter int GAMMA1_BITS = 19,
    parameter int RATE_BYTES  = 136,
    parameter int N           = 256,
    parameter int COEF_W      = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_blk_ready,
    input  logic                    i_blk_valid,
    input  logic [RATE_BYTES*8-1:0] i_blk_data,
    output logic                    o_coef_valid,
    input  logic                    i_coef_ready,
`ifdef POLY_GAMMA1_STREAM_IDX_EN
    output logic [7:0]              o_coef_idx,
`endif
    output logic [COEF_W-1:0]       o_coef_data
);
    localparam int CB    = GAMMA1_BITS + 1;
    localparam int BLK_W = RATE_BYTES * 8;
    // A block is only fetched when fewer than CB bits remain, so the
    // buffer never has to hold more than one block plus CB-1 residual bits.
    localparam int BUF_W = BLK_W + CB - 1;
    localparam int BC_W  = $clog2(BUF_W + 1);
    localparam int CC_W  = $clog2(N + 1);
    localparam logic [COEF_W-1:0] GAMMA1 = COEF_W'(1) << GAMMA1_BITS;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT, S_FINISH} state_t;

    state_t            r_state, w_state_nxt;
    logic [BUF_W-1:0]  r_buf;
    logic [BC_W-1:0]   r_bc;
    logic [CC_W-1:0]   r_cc;
    logic              w_blk_ready, w_coef_valid;
    logic              w_blk_fire, w_coef_fire;
    logic [COEF_W-1:0] w_z;

    always_comb begin
        w_state_nxt  = r_state;
        w_blk_ready  = 1'b0;
        w_coef_valid = 1'b0;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = S_FILL;
            S_FILL: begin
                w_blk_ready = 1'b1;
                if (i_blk_valid) w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                w_coef_valid = (r_bc >= BC_W'(CB));
                if (w_coef_valid && i_coef_ready) begin
                    if (r_cc == CC_W'(N - 1))
                        w_state_nxt = S_FINISH;
                    // residual after this shift is shorter than one field
                    else if (r_bc < BC_W'(2 * CB))
                        w_state_nxt = S_FILL;
                end else if (!w_coef_valid) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_blk_fire  = w_blk_ready & i_blk_valid;
    assign w_coef_fire = w_coef_valid & i_coef_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_bc    <= '0;
            r_cc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && i_start) begin
                // leftover bits of the previous run are dropped here
                r_buf <= '0;
                r_bc  <= '0;
                r_cc  <= '0;
            end else if (w_blk_fire) begin
                r_buf <= r_buf | ({{(CB-1){1'b0}}, i_blk_data} << r_bc);
                r_bc  <= r_bc + BC_W'(BLK_W);
            end else if (w_coef_fire) begin
                r_buf <= r_buf >> CB;
                r_bc  <= r_bc - BC_W'(CB);
                r_cc  <= r_cc + CC_W'(1);
            end
        end
    end

    // t < 2^CB and GAMMA1 = 2^(CB-1), so the difference fits COEF_W signed
    assign w_z = GAMMA1 - {{(COEF_W-CB){1'b0}}, r_buf[CB-1:0]};

    assign o_busy       = (r_state == S_FILL) || (r_state == S_EMIT);
    assign o_done       = (r_state == S_FINISH);
    assign o_blk_ready  = w_blk_ready;
    assign o_coef_valid = w_coef_valid;
    // gated so the bus reads zero outside EMIT (and right after reset)
    assign o_coef_data  = w_coef_valid ? w_z : '0;
`ifdef POLY_GAMMA1_STREAM_IDX_EN
    assign o_coef_idx   = w_coef_valid ? r_cc[7:0] : 8'd0;
`endif
endmodule

// File: tb/tb_poly_uniform_gamma1_stream.sv
// Scoreboard bench: lane 0 is a GAMMA1_BITS=19 instance, lane 1 a
// GAMMA1_BITS=17 instance. Expected coefficients are queued when a
// polynomial's block stream is loaded; a monitor pops on every handshake.
module tb_poly_uniform_gamma1_stream;
    localparam int BLK_W = 1088;
    localparam int NBLK  = 5;
    localparam int NC    = 256;

    logic clk = 1'b0;
    logic reset;
    logic             start[2], busy[2], done[2], blk_ready[2], blk_valid[2];
    logic             coef_valid[2], coef_ready[2];
    logic [BLK_W-1:0] blk_data[2];
    logic [31:0]      coef_data[2];
`ifdef POLY_GAMMA1_STREAM_IDX_EN
    logic [7:0]       idx[2];
`endif

    always #5 clk = ~clk;

    poly_uniform_gamma1_stream #(.GAMMA1_BITS(19)) dut0 (
        .i_clock(clk), .i_reset(reset), .i_start(start[0]), .o_busy(busy[0]),
        .o_done(done[0]), .o_blk_ready(blk_ready[0]), .i_blk_valid(blk_valid[0]),
        .i_blk_data(blk_data[0]), .o_coef_valid(coef_valid[0]),
        .i_coef_ready(coef_ready[0]),
`ifdef POLY_GAMMA1_STREAM_IDX_EN
        .o_coef_idx(idx[0]),
`endif
        .o_coef_data(coef_data[0]));

    poly_uniform_gamma1_stream #(.GAMMA1_BITS(17)) dut1 (
        .i_clock(clk), .i_reset(reset), .i_start(start[1]), .o_busy(busy[1]),
        .o_done(done[1]), .o_blk_ready(blk_ready[1]), .i_blk_valid(blk_valid[1]),
        .i_blk_data(blk_data[1]), .o_coef_valid(coef_valid[1]),
        .i_coef_ready(coef_ready[1]),
`ifdef POLY_GAMMA1_STREAM_IDX_EN
        .o_coef_idx(idx[1]),
`endif
        .o_coef_data(coef_data[1]));

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int exp0[$], exp1[$];
    logic [NBLK*BLK_W-1:0] strm[2];
    int cnt[2], blk_cnt[2], last_hs[2];
    bit prev_stall[2];
    logic [31:0] prev_data[2];

    function automatic void chk(bit ok, string nm, longint act, longint expv);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endfunction

    function automatic void qpush(int l, int v);
        if (l == 0) exp0.push_back(v); else exp1.push_back(v);
    endfunction

    function automatic int qpop(int l);
        if (l == 0) return exp0.pop_front();
        return exp1.pop_front();
    endfunction

    function automatic int qsize(int l);
        return (l == 0) ? exp0.size() : exp1.size();
    endfunction

    // mode 0 zeros, 1 ones, 2 straddle (lane 1 only), 3 random bytes
    task automatic load(input int l, input int mode);
        int cb, g1;
        logic [19:0] t;
        cb = (l == 0) ? 20 : 18;
        g1 = (l == 0) ? 524288 : 131072;
        if (l == 0) exp0.delete(); else exp1.delete();
        strm[l] = '0;
        case (mode)
            0: for (int k = 0; k < NC; k++) qpush(l, (l == 0) ? 524288 : 131072);
            1: begin
                strm[l] = '1;
                for (int k = 0; k < NC; k++) qpush(l, (l == 0) ? -524287 : -131071);
            end
            2: begin
                // block 0 bits [1087:1080] = 0xFF, everything else zero:
                // coefficient 60 spans bits 1080..1097 -> t = 0xFF
                strm[l][1087:1080] = 8'hFF;
                for (int k = 0; k < NC; k++) qpush(l, (k == 60) ? 130817 : 131072);
            end
            default: begin
                for (int i = 0; i < NBLK*BLK_W/32; i++) strm[l][i*32 +: 32] = $urandom;
                for (int k = 0; k < NC; k++) begin
                    t = strm[l][k*cb +: 20];
                    if (cb == 18) t[19:18] = 2'b00;
                    qpush(l, g1 - int'(t));
                end
            end
        endcase
    endtask

    task automatic run_poly(input int l, input int rdy_pct, input int maxdly,
                            input int abort_at, input bit spur);
        int bi = 0, wt = 0, t = 0;
        bit ok = 0, pulsed = 0;
        blk_cnt[l] = 0;
        cnt[l] = 0;
        @(posedge clk); #1;
        start[l] = 1'b1;
        @(posedge clk); #1;
        start[l] = 1'b0;
        chk(busy[l] == 1'b1, "busy_after_start", busy[l], 1);
        while (t < 20000) begin
            start[l] = 1'b0;
            coef_ready[l] = ($urandom_range(0, 99) < rdy_pct);
            if (blk_ready[l]) begin
                if (wt > 0) begin
                    wt--;
                    blk_valid[l] = 1'b0;
                end else begin
                    blk_valid[l] = 1'b1;
                    blk_data[l] = (bi < NBLK) ? strm[l][bi*BLK_W +: BLK_W] : '0;
                    bi++;
                    wt = (maxdly > 0) ? $urandom_range(0, maxdly) : 0;
                end
            end else begin
                // junk on the bus while not requested must be ignored
                blk_valid[l] = (maxdly > 0) && ($urandom_range(0, 3) == 0);
                blk_data[l] = {34{$urandom}};
            end
            if (abort_at >= 0 && cnt[l] == abort_at) begin
                coef_ready[l] = 1'b0;
                blk_valid[l] = 1'b0;
                reset = 1'b1;
                @(posedge clk); #1;
                chk(busy[l] == 0, "rst_busy", busy[l], 0);
                chk(done[l] == 0, "rst_done", done[l], 0);
                chk(blk_ready[l] == 0, "rst_blk_ready", blk_ready[l], 0);
                chk(coef_valid[l] == 0, "rst_coef_valid", coef_valid[l], 0);
                chk(coef_data[l] == 0, "rst_coef_data", coef_data[l], 0);
                reset = 1'b0;
                if (l == 0) exp0.delete(); else exp1.delete();
                return;
            end
            if (spur && !pulsed && cnt[l] == 50) begin
                start[l] = 1'b1;
                pulsed = 1;
            end
            if (done[l]) begin
                ok = 1;
                if (spur) start[l] = 1'b1;
                break;
            end
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        start[l] = 1'b0;
        blk_valid[l] = 1'b0;
        coef_ready[l] = 1'b0;
        chk(ok, "done_timeout", ok, 1);
        chk(blk_cnt[l] == NBLK, "blk_count", blk_cnt[l], NBLK);
        chk(qsize(l) == 0, "coefs_missing", qsize(l), 0);
        repeat (4) @(posedge clk);
        #1;
        chk(!busy[l] && !blk_ready[l], "no_rerun", busy[l], 0);
    endtask

    // monitor / scoreboard
    initial begin
        int e;
        forever begin
            @(negedge clk);
            cyc++;
            for (int l = 0; l < 2; l++) begin
                if (reset) begin
                    prev_stall[l] = 0;
                    continue;
                end
                chk(!(coef_valid[l] && blk_ready[l]), "valid_ready_excl",
                    coef_valid[l], 0);
                if (prev_stall[l])
                    chk(coef_valid[l] && coef_data[l] == prev_data[l], "stall_hold",
                        coef_data[l], prev_data[l]);
                prev_stall[l] = coef_valid[l] && !coef_ready[l];
                prev_data[l] = coef_data[l];
                if (blk_valid[l] && blk_ready[l]) blk_cnt[l]++;
                if (coef_valid[l] && coef_ready[l]) begin
                    if (qsize(l) == 0) begin
                        chk(0, "extra_coef", cnt[l], NC);
                    end else begin
                        e = qpop(l);
                        chk($signed(coef_data[l]) == e,
                            $sformatf("coef_l%0d_k%0d", l, cnt[l]),
                            $signed(coef_data[l]), e);
                    end
`ifdef POLY_GAMMA1_STREAM_IDX_EN
                    chk(idx[l] == 8'(cnt[l]), "coef_idx", idx[l], cnt[l] % 256);
`endif
                    cnt[l]++;
                    last_hs[l] = cyc;
                end
                if (done[l]) begin
                    chk(cyc == last_hs[l] + 1, "done_timing", cyc - last_hs[l], 1);
                    chk(cnt[l] == NC, "coef_count", cnt[l], NC);
                    chk(busy[l] == 0, "busy_falls_with_done", busy[l], 0);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int l = 0; l < 2; l++) begin
            start[l] = 0; blk_valid[l] = 0; coef_ready[l] = 0; blk_data[l] = '0;
            cnt[l] = 0; blk_cnt[l] = 0; last_hs[l] = 0; prev_stall[l] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            chk(busy[l] == 0, "reset_busy", busy[l], 0);
            chk(done[l] == 0, "reset_done", done[l], 0);
            chk(blk_ready[l] == 0, "reset_blk_ready", blk_ready[l], 0);
            chk(coef_valid[l] == 0, "reset_coef_valid", coef_valid[l], 0);
            chk(coef_data[l] == 0, "reset_coef_data", coef_data[l], 0);
        end
        reset = 1'b0;

        load(0, 0); run_poly(0, 100, 0, -1, 0);   // zeros, gamma1 = 2^19
        load(1, 1); run_poly(1, 100, 0, -1, 0);   // ones,  gamma1 = 2^17
        load(1, 2); run_poly(1, 100, 0, -1, 0);   // block-boundary straddle
        load(0, 3); run_poly(0, 50, 3, -1, 0);    // random data, stalls
        load(1, 3); run_poly(1, 50, 3, -1, 0);
        load(0, 3); run_poly(0, 100, 0, 100, 0);  // reset at cc = 100
        load(0, 3); run_poly(0, 100, 1, -1, 0);   // full run after abort
        load(0, 3); run_poly(0, 70, 2, -1, 1);    // spurious starts ignored

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/poly_uniform_gamma1_stream.md
Name: poly_uniform_gamma1_stream

Overview:
Parametrised, streaming successor of the fixed gamma1 sampler. Accepts SHAKE256 squeeze blocks (136 B) over a valid/ready handshake and bit-unpacks (GAMMA1_BITS+1)-bit fields. Emits 256 signed coefficients z = GAMMA1 - t, one per cycle, with backpressure. Supports both Dilithium gamma1 settings (2^17, 2^19) and sits between the shake256 stream/squeeze cores and the mask-vector (y) generator.

Parameters:
GAMMA1_BITS, 19, log2(gamma1); legal values 17 or 19; coefficient field width CB = GAMMA1_BITS+1.
RATE_BYTES, 136, bytes per squeeze block; block bus width = RATE_BYTES*8.
N, 256, coefficients per polynomial.
COEF_W, 32, output coefficient width (two's complement).

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high; clears all state
start  in  1  begin one polynomial; sampled only in IDLE
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last coefficient handshake
blk_ready  out  1  block requested
blk_valid  in  1  blk_data valid
blk_data  in  RATE_BYTES*8  squeeze block, byte 0 in bits [7:0], LSB-first bit order
coef_valid  out  1  coef_data valid
coef_ready  in  1  downstream accepts
coef_data  out  COEF_W  sign-extended GAMMA1 - t

Behaviour:
- Reset values: busy=0, done=0, blk_ready=0, coef_valid=0, coef_data=0. Bit buffer, bit count and coefficient count are cleared. Reset mid-operation aborts immediately; no done pulse.
- Internal state:
  - bit buffer, width RATE_BYTES*8+CB-1, LSB = oldest bit;
  - bit count bc (0..RATE_BYTES*8+CB-1);
  - coefficient count cc (0..N).
- FSM states IDLE, FILL, EMIT, FINISH:
- IDLE: start=1 clears bc and cc and goes to FILL. start=0 holds.
- FILL: blk_ready=1. On blk_valid&blk_ready, buffer |= blk_data << bc, bc += RATE_BYTES*8, then go to EMIT. blk_valid is ignored while blk_ready=0.
- EMIT: coef_valid=1 while bc >= CB. t = buffer[CB-1:0] (unsigned); coef_data = GAMMA1 - t, sign-extended to COEF_W.
  - On coef_valid&coef_ready: buffer >>= CB, bc -= CB, cc += 1.
  - coef_data and coef_valid are held stable while coef_ready=0.
  - cc reaches N: go to FINISH. Otherwise, if bc < CB: go to FILL, retaining residual bits (fields straddle block boundaries).
- FINISH: done=1 for exactly one cycle, then IDLE. Leftover buffer bits are discarded.
- Block counts: exactly ceil(N*CB/(RATE_BYTES*8)) blocks are requested, i.e. 5 for both 17 and 19; no extra block is ever requested.
- Throughput:
  - one coefficient per cycle under coef_ready=1;
  - one-cycle bubble per block fetch, plus the upstream latency.
- Start while busy is ignored. start asserted in the same cycle as done is ignored; it must be re-asserted once in IDLE.
- Coefficient range: (-GAMMA1, GAMMA1]. The subtraction is done in COEF_W bits and cannot overflow.
- coef_valid and blk_ready are never high in the same cycle.

Optional Feature:
Macro POLY_GAMMA1_STREAM_IDX_EN.
- Defined: adds output coef_idx [7:0]. It equals cc for the coefficient currently on coef_data, is held stable with coef_data, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- GAMMA1_BITS=19, 5 all-zero blocks, coef_ready=1 -> 256 coefficients of 524288, exactly 5 blk handshakes, done one cycle after the 256th handshake.
- GAMMA1_BITS=17, all-ones blocks -> every coefficient is -131071 (t=262143). Exactly 5 blocks; the 5th block is only partly used; busy falls with done.
- GAMMA1_BITS=17 straddle check: block 0 bits [1087:1080]=0xFF, block 1 bits [9:0]=0 -> coefficient 60 has t=0x000FF, z=130817. Coefficients 0..59 computed from block 0 only.
- Random coef_ready (~50%) with random blk_valid delays vs. a C reference polyz_unpack over the same 680 bytes -> identical sequence. coef_data is stable during every stall.
- Reset asserted at cc=100 -> next cycle all outputs 0 and state IDLE. A subsequent start produces a full, correct 256-coefficient run.
- start pulsed during EMIT, and start in the done cycle -> both ignored. The run is unaffected; no second run begins until start is re-asserted in IDLE.
